// File: rtl/spimem_arb.sv
// spimem_arb: shares the single spimemio read port between instruction fetch
// (port 0) and data load (port 1). Config-register accesses are sequenced so
// that a cfgreg write never lands while a flash transfer is in flight. A grant
// is held until spimemio returns ready, so its sequential-prefetch stays intact.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   p0_* / p1_*         requester read ports (valid/ready/addr/rdata)
//   cfg_valid/wstrb/wdata/ready/rdata
//                       config access; wstrb==0 is a read, rdata = cfgreg_do
//   mem_valid/ready/addr/rdata
//                       shared spimemio read port
//   cfgreg_we/di/do     spimemio config register interface
//   err                 sticky grant-timeout flag
//
// Build option:
//   SPIMEM_ARB_TIMEOUT_EN  when defined, a granted read that waits TIMEOUT
//                          cycles without mem_ready is aborted: the requester
//                          gets ready with all-ones data and err is set.
//                          When undefined a grant waits indefinitely, err = 0.

module spimem_arb #(
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        p0_valid,
    output logic        p0_ready,
    input  logic [23:0] p0_addr,
    output logic [31:0] p0_rdata,

    input  logic        p1_valid,
    output logic        p1_ready,
    input  logic [23:0] p1_addr,
    output logic [31:0] p1_rdata,

    input  logic        cfg_valid,
    input  logic [3:0]  cfg_wstrb,
    input  logic [31:0] cfg_wdata,
    output logic        cfg_ready,
    output logic [31:0] cfg_rdata,

    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [23:0] mem_addr,
    input  logic [31:0] mem_rdata,

    output logic [3:0]  cfgreg_we,
    output logic [31:0] cfgreg_di,
    input  logic [31:0] cfgreg_do,

    output logic        err
);

    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    if (MAX_STREAK < 1 || TIMEOUT < 1 || TIMEOUT > 2047) begin : g_param_check
        $error("spimem_arb: MAX_STREAK must be >= 1 and TIMEOUT in 1..2047");
    end

    typedef enum logic [1:0] {IDLE, G0, G1, CFG} state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] streak, streak_nxt;
    logic          to_hit;

    // ---- state / fairness registers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= state_nxt;
            streak <= streak_nxt;
        end
    end

    // ---- arbitration decision and granted-port datapath ----
    always_comb begin
        state_nxt  = state;
        streak_nxt = streak;
        mem_valid  = 1'b0;
        mem_addr   = '0;
        p0_ready   = 1'b0;
        p0_rdata   = '0;
        p1_ready   = 1'b0;
        p1_rdata   = '0;
        cfg_ready  = 1'b0;
        cfgreg_we  = '0;
        cfgreg_di  = '0;

        case (state)
            IDLE: begin
                // Config first so cfgreg writes slot between transfers; a
                // port-1 request that has lost MAX_STREAK times is forced next.
                if (cfg_valid) begin
                    state_nxt = CFG;
                end else if (p1_valid && streak == STREAK_MAX) begin
                    state_nxt  = G1;
                    streak_nxt = '0;
                end else if (p0_valid) begin
                    state_nxt = G0;
                    if (p1_valid)
                        streak_nxt = (streak == STREAK_MAX) ? streak : streak + 1'b1;
                    else
                        streak_nxt = '0;
                end else if (p1_valid) begin
                    state_nxt  = G1;
                    streak_nxt = '0;
                end
            end

            G0: begin
                mem_valid = p0_valid && !to_hit;
                mem_addr  = p0_addr;
                p0_ready  = mem_ready || to_hit;
                p0_rdata  = to_hit ? 32'hFFFF_FFFF : mem_rdata;
                // A requester dropping valid before ready abandons the read.
                if (mem_ready || !p0_valid || to_hit)
                    state_nxt = IDLE;
            end

            G1: begin
                mem_valid = p1_valid && !to_hit;
                mem_addr  = p1_addr;
                p1_ready  = mem_ready || to_hit;
                p1_rdata  = to_hit ? 32'hFFFF_FFFF : mem_rdata;
                if (mem_ready || !p1_valid || to_hit)
                    state_nxt = IDLE;
            end

            CFG: begin
                cfg_ready = 1'b1;
                cfgreg_we = cfg_wstrb;
                cfgreg_di = cfg_wdata;
                state_nxt = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

    assign cfg_rdata = cfgreg_do;

`ifdef SPIMEM_ARB_TIMEOUT_EN
    localparam logic [10:0] TO_LAST = 11'(TIMEOUT - 1);

    logic [10:0] wait_cnt;
    logic        grant_start;
    logic        granted;

    assign grant_start = (state == IDLE) && (state_nxt == G0 || state_nxt == G1);
    assign granted     = (state == G0) || (state == G1);

    // Count is 0 in the first grant cycle, so the abort lands in grant
    // cycle TIMEOUT. A real completion in that cycle takes precedence.
    assign to_hit = ((state == G0 && p0_valid) || (state == G1 && p1_valid)) &&
                    !mem_ready && (wait_cnt == TO_LAST);

    // ---- grant watchdog ----
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (grant_start)
                wait_cnt <= '0;
            else if (granted && !mem_ready)
                wait_cnt <= wait_cnt + 11'd1;
            if (to_hit)
                err <= 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
    assign err    = 1'b0;
`endif

endmodule
